// File: rtl/bsw_pkg.sv
// Shared types and constants for the bootstrapped sampling switch sequencer.
package bsw_pkg;

  localparam int unsigned PH_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    NOV1,
    TRACK,
    NOV2,
    HOLD
  } bsw_state_e;

  localparam logic BSW_CK_RST  = 1'b0;
  localparam logic BSW_CKB_RST = 1'b1;

endpackage

// File: rtl/bsw_phase_gen.sv
// Registered state-to-phase decoder; the single place the CK/CKB non-overlap is guaranteed.
module bsw_phase_gen
  import bsw_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  bsw_state_e state_nxt,
  output logic       bsw_ck,
  output logic       bsw_ckb
);

  logic ck_d;
  logic ckb_d;

  // A phase may only rise once the opposite phase register is already low.
  always_comb begin
    ck_d  = (state_nxt == TRACK) && !bsw_ckb;
    ckb_d = ((state_nxt == IDLE) || (state_nxt == PRE) || (state_nxt == HOLD)) && !bsw_ck;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bsw_ck  <= BSW_CK_RST;
      bsw_ckb <= BSW_CKB_RST;
    end else begin
      bsw_ck  <= ck_d;
      bsw_ckb <= ckb_d;
    end
  end

endmodule

// File: rtl/bsw_sample_ctrl.sv
// Sampling-switch sequencer: phase timing FSM, conversion handshake and sample counter.
module bsw_sample_ctrl
  import bsw_pkg::*;
#(
  parameter int unsigned TRACK_CYC = 8,
  parameter int unsigned NOV_CYC   = 1,
  parameter int unsigned PRE_CYC   = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             cont,
  input  logic             conv_ack,
  output logic             bsw_ck,
  output logic             bsw_ckb,
  output logic             conv_req,
  output logic             busy,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam logic [PH_CNT_W-1:0] PRE_LD   = PH_CNT_W'(PRE_CYC - 1);
  localparam logic [PH_CNT_W-1:0] NOV_LD   = PH_CNT_W'(NOV_CYC - 1);
  localparam logic [PH_CNT_W-1:0] TRACK_LD = PH_CNT_W'(TRACK_CYC - 1);

  bsw_state_e          state_q;
  bsw_state_e          state_nxt;
  logic [PH_CNT_W-1:0] ph_cnt_q;
  logic [PH_CNT_W-1:0] ph_cnt_nxt;
  logic                abort_q;
  logic                abort_nxt;
  logic                ph_done;
  logic                ack_take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ph_cnt_q   <= '0;
      abort_q    <= 1'b0;
      conv_req   <= 1'b0;
      busy       <= 1'b0;
      sample_cnt <= '0;
    end else begin
      state_q  <= state_nxt;
      ph_cnt_q <= ph_cnt_nxt;
      abort_q  <= abort_nxt;
      conv_req <= (state_nxt == HOLD);
      busy     <= (state_nxt != IDLE);
      if (ack_take) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
      end
    end
  end

  // Next state; the phase timer reloads on every state change.
  always_comb begin
    state_nxt  = state_q;
    ph_cnt_nxt = ph_cnt_q;
    ph_done    = (ph_cnt_q == '0);
    ack_take   = (state_q == HOLD) && conv_ack;

    case (state_q)
      IDLE:  if (start && en) state_nxt = PRE;
      PRE:   if (!en) state_nxt = IDLE; else if (ph_done) state_nxt = NOV1;
      NOV1:  if (!en) state_nxt = IDLE; else if (ph_done) state_nxt = TRACK;
      TRACK: if (!en || ph_done) state_nxt = NOV2;
      NOV2: begin
        if (!en) state_nxt = IDLE;
        else if (ph_done) state_nxt = abort_q ? IDLE : HOLD;
      end
      HOLD:  if (conv_ack) state_nxt = (cont && en) ? PRE : IDLE;
      default: state_nxt = IDLE;
    endcase

    // An aborted track must not produce a held sample.
    abort_nxt = (state_nxt == NOV2) && (abort_q || ((state_q == TRACK) && !en));

    if (state_nxt != state_q) begin
      case (state_nxt)
        PRE:         ph_cnt_nxt = PRE_LD;
        NOV1, NOV2:  ph_cnt_nxt = NOV_LD;
        TRACK:       ph_cnt_nxt = TRACK_LD;
        default:     ph_cnt_nxt = '0;
      endcase
    end else if (!ph_done) begin
      ph_cnt_nxt = ph_cnt_q - PH_CNT_W'(1);
    end
  end

  bsw_phase_gen u_phase_gen (
    .clk       (clk),
    .rst       (rst),
    .state_nxt (state_nxt),
    .bsw_ck    (bsw_ck),
    .bsw_ckb   (bsw_ckb)
  );

endmodule

// File: doc/bsw_sample_ctrl.md
Name: bsw_sample_ctrl

Overview:
- Sequencer for the bootstrapped sampling switch.
- Generates the non-overlapping CK/CKB phase pair that drives the switch:
  - CKB high precharges the bootstrap capacitor and holds the switch off.
  - CK high turns the switch on so it tracks VIN.
- Times the track window, then hands each held sample to the downstream converter via a req/ack handshake.
- Sits between the digital conversion controller and the analog switch macro.

Parameters:
- TRACK_CYC, 8, CK-high (track) duration in CLK cycles; legal range 1..255.
- NOV_CYC, 1, non-overlap gap (both phases low) in CLK cycles; legal range 1..15.
- PRE_CYC, 2, minimum CKB-high precharge before each track, in CLK cycles; legal range 1..15.
- CNT_W, 16, width of the sample counter.

Ports:
- CLK  input  1  system clock
- RST  input  1  asynchronous active-high reset
- EN  input  1  block enable; low forces a graceful return to IDLE
- START  input  1  single-pulse sample request, sampled in IDLE only
- CONT  input  1  continuous mode: re-arm automatically after each ack
- CONV_ACK  input  1  converter has captured the held sample
- BSW_CK  output  1  switch-on phase to the switch
- BSW_CKB  output  1  precharge/off phase to the switch
- CONV_REQ  output  1  held sample valid, request conversion
- BUSY  output  1  high in any state other than IDLE
- SAMPLE_CNT  output  CNT_W  completed handshakes, wraps modulo 2^CNT_W

Behaviour:
- Single clock; reset is asynchronous and active-high (RST). All outputs are registered.
- Reset values: BSW_CK=0, BSW_CKB=1, CONV_REQ=0, BUSY=0, SAMPLE_CNT=0, state=IDLE.
- Safety invariant: BSW_CK and BSW_CKB are never both 1 in any cycle, including reset entry/exit and EN drop.
- States and transitions (one shared down-counter, 8 bits, reloaded on every state entry):
  - IDLE: CKB=1, CK=0. Go to PRE when START=1 and EN=1.
  - PRE: CKB=1 for PRE_CYC cycles, then NOV1.
  - NOV1: CK=0, CKB=0 for NOV_CYC cycles, then TRACK.
  - TRACK: CK=1 for TRACK_CYC cycles, then NOV2.
  - NOV2: both phases low for NOV_CYC cycles, then HOLD.
  - HOLD: CKB=1, CONV_REQ=1. Stay until CONV_ACK=1.
  - On ack:
    - CONV_REQ drops next cycle.
    - SAMPLE_CNT increments by 1.
    - Next state is PRE if CONT=1 and EN=1; otherwise IDLE.
- Latency:
  - START accepted at edge n gives first BSW_CK=1 at edge n+PRE_CYC+NOV_CYC.
  - CONV_REQ rises at edge n+PRE_CYC+2*NOV_CYC+TRACK_CYC.
- Handshake:
  - CONV_REQ stays high until acked; CONV_ACK is ignored outside HOLD.
  - CONV_ACK may arrive in the first HOLD cycle. Minimum HOLD length is 1 cycle.
- EN deasserted:
  - In PRE, NOV1 or NOV2: go to IDLE next cycle.
  - In TRACK: go to NOV2, then IDLE after the gap (HOLD is skipped, no count increment). CK must not fall and CKB rise in the same cycle.
  - In HOLD: wait for the ack, then IDLE.
- START while BUSY: ignored, no queuing.
- SAMPLE_CNT: wraps from all-ones to 0 without a flag.
- Asynchronous reset mid-operation:
  - Outputs return to their reset values immediately.
  - A pending CONV_REQ is dropped without ack; the downstream side must tolerate this.

Decomposition:
- Shared package bsw_pkg holds:
  - the state enum typedef (IDLE, PRE, NOV1, TRACK, NOV2, HOLD);
  - the 8-bit phase-counter width constant;
  - the reset-value constants for the phase outputs.
- One natural sub-module: bsw_phase_gen, a registered decoder from state to BSW_CK/BSW_CKB that enforces the non-overlap invariant in one place.
- FSM, timer and sample counter stay in the top level.

Test Plan:
- Reset then single START, defaults, CONT=0 -> CK=0/CKB=1 in IDLE; CKB high 2 cycles; 1-cycle both-low gap; CK high exactly 8 cycles; 1-cycle gap; CONV_REQ=1. Ack after 3 cycles -> CONV_REQ=0 next cycle, SAMPLE_CNT=1, BUSY=0.
- CONT=1, ack in the first HOLD cycle, 4 samples -> back-to-back PRE re-entry, period 2+1+8+1+1=13 cycles, SAMPLE_CNT=4. Overlap checker never fires.
- EN dropped on the 4th TRACK cycle -> CK falls next cycle, 1 gap cycle, then IDLE with CKB=1; CONV_REQ never asserts; SAMPLE_CNT unchanged.
- START pulsed during TRACK and during HOLD -> ignored; exactly one sample completes.
- RST asserted asynchronously mid-TRACK -> CK=0, CKB=1, CONV_REQ=0 without waiting for a clock edge; after release, IDLE and SAMPLE_CNT=0.
- CNT_W=4, 17 samples in CONT mode -> SAMPLE_CNT wraps 15→0 and reads 1 at the end. Random NOV_CYC/TRACK_CYC sweep -> CK&CKB always 0 (assertion).
